// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Port-priority resolution lives here so bypass and scoreboard agree on it.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;
    localparam int REG_A0   = 10;

    // Upper bound on write ports; hit vectors are zero-padded to this width.
    localparam int MAX_PORTS = 8;

    // Index of the highest set bit in a port-hit vector, or -1 if none is set.
    function automatic int highestPort(input logic [MAX_PORTS-1:0] hits);
        int sel;
        sel = -1;
        for (int p = 0; p < MAX_PORTS; p++) begin
            if (hits[p]) begin
                sel = p;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and
// cleared on writeback, with a new issue taking precedence over a retiring write.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NWR   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        logic [MAX_PORTS-1:0] hits;
        busy_d = busy_q;
        hits   = '0;
        for (int r = 1; r < NREGS; r++) begin
            hits = '0;
            for (int w = 0; w < NWR; w++) begin
                hits[w] = wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r));
            end
            if (highestPort(hits) >= 0) begin
                busy_d[r] = 1'b0;
            end
            if (iss_en && (iss_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-first bypass on every read port,
// hard-wired x0, a pending-write scoreboard and a registered debug tap.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN    = XLEN_DEF,
    parameter  int NREGS   = NREGS_DEF,
    parameter  int NRD     = 2,
    parameter  int NWR     = 2,
    parameter  int DBG_REG = REG_A0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREGS-1:0]    busy_vec,
    output logic [XLEN-1:0]     dbg_q
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Ascending port order lets the highest-index writer land last and win.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != AW'(REG_ZERO))) begin
                regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .busy_vec (busy_vec)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]        addr;
        logic [MAX_PORTS-1:0] hits;
        int                   hp;
        logic [XLEN-1:0]      data;

        always_comb begin
            addr = rs_addr[i*AW +: AW];
            hits = '0;
            for (int w = 0; w < NWR; w++) begin
                hits[w] = wr_en[w] && (wr_addr[w*AW +: AW] == addr);
            end
            hp   = highestPort(hits);
            data = regs_q[addr];
            for (int w = 0; w < NWR; w++) begin
                if (hp == w) begin
                    data = wr_data[w*XLEN +: XLEN];
                end
            end
            if (rst || (addr == AW'(REG_ZERO))) begin
                data = '0;
            end
        end

        // A same-cycle writeback satisfies the consumer through the bypass.
        assign rs_data[i*XLEN +: XLEN] = data;
        assign rs_busy[i] = !rst && busy_vec[addr] && (hp < 0);
    end

    assign dbg_q = regs_q[DBG_REG];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp: a register-array reference model
// predicts each cycle's outputs, and a monitor compares them at the falling edge.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic                 clk;
    logic                 rst;
    logic [2*AW-1:0]      rs_addr;
    logic [2*XLEN-1:0]    rs_data;
    logic [1:0]           rs_busy;
    logic [1:0]           wr_en;
    logic [2*AW-1:0]      wr_addr;
    logic [2*XLEN-1:0]    wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_rd;
    logic [NREGS-1:0]     busy_vec;
    logic [XLEN-1:0]      dbg_q;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic [31:0] bv;
        logic [31:0] dbg;
    } exp_t;

    exp_t expQ[$];

    logic [31:0] modelRegs [NREGS];
    bit          modelBusy [NREGS];

    int checks   = 0;
    int passes   = 0;
    int failures = 0;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .busy_vec (busy_vec),
        .dbg_q    (dbg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelClear();
        for (int r = 0; r < NREGS; r++) begin
            modelRegs[r] = 32'h0;
            modelBusy[r] = 1'b0;
        end
    endtask

    // Reference read: x0 is zero, the highest-numbered writer to the address
    // supplies the data, otherwise the stored value.
    function automatic logic [31:0] modelRead(input logic [4:0] a, input logic r,
                                              input logic [1:0] we, input logic [4:0] wa0,
                                              input logic [4:0] wa1, input logic [31:0] wd0,
                                              input logic [31:0] wd1);
        if (r || a == 5'd0) return 32'h0;
        if (we[1] && wa1 == a) return wd1;
        if (we[0] && wa0 == a) return wd0;
        return modelRegs[a];
    endfunction

    function automatic logic modelStall(input logic [4:0] a, input logic r, input logic [1:0] we,
                                        input logic [4:0] wa0, input logic [4:0] wa1);
        if (r) return 1'b0;
        if ((we[0] && wa0 == a) || (we[1] && wa1 == a)) return 1'b0;
        return modelBusy[a];
    endfunction

    task automatic applyStimulus(input logic r, input logic [1:0] we,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic ie, input logic [4:0] ird,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t e;
        rst     = r;
        wr_en   = we;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        iss_en  = ie;
        iss_rd  = ird;
        rs_addr = {ra1, ra0};
        if (r) modelClear();
        e.d0   = modelRead(ra0, r, we, wa0, wa1, wd0, wd1);
        e.d1   = modelRead(ra1, r, we, wa0, wa1, wd0, wd1);
        e.busy = {modelStall(ra1, r, we, wa0, wa1), modelStall(ra0, r, we, wa0, wa1)};
        e.bv   = '0;
        for (int k = 0; k < NREGS; k++) e.bv[k] = modelBusy[k];
        e.dbg  = modelRegs[10];
        expQ.push_back(e);
        @(posedge clk);
        if (r) begin
            modelClear();
        end else begin
            if (we[0] && wa0 != 5'd0) begin modelRegs[wa0] = wd0; modelBusy[wa0] = 1'b0; end
            if (we[1] && wa1 != 5'd0) begin modelRegs[wa1] = wd1; modelBusy[wa1] = 1'b0; end
            if (ie && ird != 5'd0) modelBusy[ird] = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, ra0, ra1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: one expected record is queued per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("rs_data0", rs_data[31:0], e.d0);
                checkOutput("rs_data1", rs_data[63:32], e.d1);
                checkOutput("rs_busy", {30'd0, rs_busy}, {30'd0, e.busy});
                checkOutput("busy_vec", busy_vec, e.bv);
                checkOutput("dbg_q", dbg_q, e.dbg);
            end
        end
    end

    initial begin
        int waitCycles;
        rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_rd = '0; rs_addr = '0;
        modelClear();
        @(posedge clk); #1;

        applyStimulus(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd10);
        idle(5'd5, 5'd0);

        // Reset arriving while a write is held.
        applyStimulus(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd6);
        applyStimulus(1'b1, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd6);
        idle(5'd5, 5'd6);

        // x0 immunity.
        applyStimulus(1'b0, 2'b10, 5'd0, 32'h0, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Dual-write collision.
        applyStimulus(1'b0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
        idle(5'd7, 5'd7);

        // Bypass on both ports.
        applyStimulus(1'b0, 2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
        idle(5'd3, 5'd3);

        // Scoreboard lifecycle.
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4);
        idle(5'd4, 5'd4);
        applyStimulus(1'b0, 2'b01, 5'd4, 32'h99, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
        idle(5'd4, 5'd4);

        // Set/clear race.
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        applyStimulus(1'b0, 2'b10, 5'd0, 32'h0, 5'd9, 32'h77, 1'b1, 5'd9, 5'd9, 5'd9);
        idle(5'd9, 5'd9);

        // Debug tap lags a write by one cycle.
        applyStimulus(1'b0, 2'b01, 5'd10, 32'hCAFE0001, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
        idle(5'd10, 5'd0);

        // Random traffic over a narrow address range to force collisions.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 15)), $urandom(),
                          5'($urandom_range(0, 15)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                          5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end
        idle(5'd0, 5'd10);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d records left, expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
